// File: rtl/axi_fanout_pkg.sv
// Shared types for the axi_fanout stream replicator.
package axi_fanout_pkg;

   typedef enum logic {
      ST_SOP = 1'b0,
      ST_MID = 1'b1
   } pkt_state_e;

   // Packet position after a beat is loaded; single-beat packets stay at SOP.
   function automatic pkt_state_e next_pkt_state(input logic last);
      return last ? ST_SOP : ST_MID;
   endfunction

endpackage

// File: rtl/axi_fanout_if.sv
// Stream bundle for axi_fanout: one input stream plus SIZE replicated output streams.
interface axi_fanout_if #(
   parameter int unsigned SIZE  = 2,
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0]      i_tdata;
   logic                  i_tlast;
   logic                  i_tvalid;
   logic                  i_tready;
   logic [SIZE*WIDTH-1:0] o_tdata;
   logic [SIZE-1:0]       o_tlast;
   logic [SIZE-1:0]       o_tvalid;
   logic [SIZE-1:0]       o_tready;

   // Environment side: drives the input stream and consumes the outputs.
   modport master (
      output i_tdata, i_tlast, i_tvalid, o_tready,
      input  i_tready, o_tdata, o_tlast, o_tvalid
   );

   // Fanout side.
   modport slave (
      input  i_tdata, i_tlast, i_tvalid, o_tready,
      output i_tready, o_tdata, o_tlast, o_tvalid
   );
endinterface

// File: rtl/axi_fanout.sv
// Replicates one AXI stream to SIZE outputs. Each output handshakes independently.
// A per-beat done mask stops a port from seeing the same beat twice.
module axi_fanout
   import axi_fanout_pkg::*;
#(
   parameter int unsigned SIZE  = 2,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [SIZE-1:0]  en_mask,
   axi_fanout_if.slave      bus,
   output logic [CNT_W-1:0] dropped_pkts
);

   logic             hold_vld, hold_vld_nxt;
   logic [WIDTH-1:0] hold_data, hold_data_nxt;
   logic             hold_last, hold_last_nxt;
   logic [SIZE-1:0]  hold_mask, hold_mask_nxt;
   logic [SIZE-1:0]  pkt_mask, pkt_mask_nxt;
   logic [SIZE-1:0]  done, done_nxt;
   pkt_state_e       state, state_nxt;
   logic [CNT_W-1:0] drop_cnt, drop_cnt_nxt;

   logic [SIZE-1:0]  o_vld;
   logic [SIZE-1:0]  fire;
   logic [SIZE-1:0]  satisfied;
   logic [SIZE-1:0]  load_mask;
   logic             retire;
   logic             in_rdy;
   logic             load;

   always_comb begin
      o_vld     = {SIZE{hold_vld}} & hold_mask & ~done;
      fire      = o_vld & bus.o_tready;
      // A port is finished with the held beat if it already took it, is masked off,
      // or is taking it right now.
      satisfied = done | ~hold_mask | fire;
      retire    = hold_vld & (&satisfied);
      in_rdy    = ~hold_vld | retire;
      load      = bus.i_tvalid & in_rdy;
      load_mask = (state == ST_SOP) ? en_mask : pkt_mask;
   end

   always_comb begin
      hold_vld_nxt  = hold_vld;
      hold_data_nxt = hold_data;
      hold_last_nxt = hold_last;
      hold_mask_nxt = hold_mask;
      pkt_mask_nxt  = pkt_mask;
      state_nxt     = state;
      drop_cnt_nxt  = drop_cnt;

      if (load) begin
         hold_vld_nxt  = 1'b1;
         hold_data_nxt = bus.i_tdata;
         hold_last_nxt = bus.i_tlast;
         hold_mask_nxt = load_mask;
         pkt_mask_nxt  = load_mask;
         state_nxt     = next_pkt_state(bus.i_tlast);
      end else if (retire) begin
         hold_vld_nxt  = 1'b0;
      end

      done_nxt = retire ? '0 : (done | fire);

      // Last beat of a fully masked packet retiring counts as one drop.
      if (retire && hold_last && (hold_mask == '0) && (drop_cnt != '1)) begin
         drop_cnt_nxt = drop_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_vld  <= 1'b0;
         hold_data <= '0;
         hold_last <= 1'b0;
         hold_mask <= '0;
         pkt_mask  <= '0;
         done      <= '0;
         state     <= ST_SOP;
         drop_cnt  <= '0;
      end else if (clear) begin
         hold_vld  <= 1'b0;
         hold_data <= '0;
         hold_last <= 1'b0;
         hold_mask <= '0;
         pkt_mask  <= '0;
         done      <= '0;
         state     <= ST_SOP;
         drop_cnt  <= '0;
      end else begin
         hold_vld  <= hold_vld_nxt;
         hold_data <= hold_data_nxt;
         hold_last <= hold_last_nxt;
         hold_mask <= hold_mask_nxt;
         pkt_mask  <= pkt_mask_nxt;
         done      <= done_nxt;
         state     <= state_nxt;
         drop_cnt  <= drop_cnt_nxt;
      end
   end

   assign bus.i_tready  = in_rdy;
   assign bus.o_tvalid  = o_vld;
   assign bus.o_tlast   = {SIZE{hold_last}} & o_vld;
   assign bus.o_tdata   = {SIZE{hold_data}};
   assign dropped_pkts  = drop_cnt;

endmodule

// File: tb/tb_axi_fanout.sv
// Randomized and directed bench for axi_fanout with per-port scoreboards.
module tb_axi_fanout;

   localparam int unsigned SIZE  = 3;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic [SIZE-1:0]  en_mask;
   logic [CNT_W-1:0] dropped_pkts;

   logic             clear2;
   logic [1:0]       en2;
   logic [1:0]       drop2;

   axi_fanout_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();
   axi_fanout_if #(.SIZE(2), .WIDTH(8)) bus2 ();

   axi_fanout #(.SIZE(SIZE), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .en_mask      (en_mask),
      .bus          (bus),
      .dropped_pkts (dropped_pkts)
   );

   // Narrow counter instance for saturation.
   axi_fanout #(.SIZE(2), .WIDTH(8), .CNT_W(2)) u_sat (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear2),
      .en_mask      (en2),
      .bus          (bus2),
      .dropped_pkts (drop2)
   );

   always #5 clk = ~clk;

   int unsigned     n_chk = 0;
   int unsigned     n_pass = 0;
   beat_t           src_q[$];
   beat_t           exp_q[SIZE][$];
   int              rx_cnt[SIZE];
   int              acc_cnt = 0;
   int              exp_drop = 0;
   logic            sop = 1'b1;
   logic [SIZE-1:0] pkt_mask = '0;
   bit              rnd_mode = 1'b0;
   bit              last_acc = 1'b0;
   int unsigned     pct[SIZE] = '{30, 60, 90};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic bit pending();
      for (int k = 0; k < SIZE; k++) if (exp_q[k].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic flush_model();
      for (int k = 0; k < SIZE; k++) exp_q[k].delete();
      sop      = 1'b1;
      pkt_mask = '0;
      exp_drop = 0;
   endtask

   task automatic push_beat(input logic [WIDTH-1:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      src_q.push_back(b);
   endtask

   task automatic clear_rx();
      for (int k = 0; k < SIZE; k++) rx_cnt[k] = 0;
   endtask

   // Drive one cycle; an offered but unaccepted beat is held stable.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!(bus.i_tvalid && !last_acc)) begin
         if (src_q.size() != 0 && (!rnd_mode || $urandom_range(9) != 0)) begin
            bus.i_tvalid = 1'b1;
            bus.i_tdata  = src_q[0].data;
            bus.i_tlast  = src_q[0].last;
         end else begin
            bus.i_tvalid = 1'b0;
         end
      end
      if (rnd_mode) begin
         for (int k = 0; k < SIZE; k++) bus.o_tready[k] = ($urandom_range(99) < pct[k]);
         if ($urandom_range(3) == 0) en_mask = SIZE'($urandom_range(7));
      end
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((src_q.size() != 0 || pending()) && n < bound) begin
         tick();
         n++;
      end
      chk("drain_in_time", 64'((src_q.size() == 0) && !pending()), 64'd1);
      repeat (3) tick();
   endtask

   // Reference model: per-port expected queues built from accepted input beats.
   initial begin
      beat_t           b;
      logic [SIZE-1:0] m;
      forever begin
         @(negedge clk);
         if (reset || clear) begin
            flush_model();
            last_acc = 1'b0;
         end else begin
            for (int k = 0; k < SIZE; k++) begin
               if (bus.o_tvalid[k]) begin
                  chk("vld_has_beat", 64'(exp_q[k].size() != 0), 64'd1);
                  if (bus.o_tready[k] && exp_q[k].size() != 0) begin
                     b = exp_q[k].pop_front();
                     chk("port_data", 64'(bus.o_tdata[k*WIDTH +: WIDTH]), 64'(b.data));
                     chk("port_last", 64'(bus.o_tlast[k]), 64'(b.last));
                     rx_cnt[k]++;
                  end
               end else begin
                  chk("last_gated", 64'(bus.o_tlast[k]), 64'd0);
               end
            end
            last_acc = bus.i_tvalid && bus.i_tready;
            if (last_acc) begin
               m        = sop ? en_mask : pkt_mask;
               pkt_mask = m;
               sop      = bus.i_tlast;
               b.data   = bus.i_tdata;
               b.last   = bus.i_tlast;
               for (int k = 0; k < SIZE; k++) if (m[k]) exp_q[k].push_back(b);
               if (bus.i_tlast && m == '0 && exp_drop < 65535) exp_drop++;
               acc_cnt++;
               if (src_q.size() != 0) void'(src_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      clear         = 1'b0;
      en_mask       = '1;
      bus.i_tvalid  = 1'b0;
      bus.i_tdata   = '0;
      bus.i_tlast   = 1'b0;
      bus.o_tready  = '1;
      clear2        = 1'b0;
      en2           = '0;
      bus2.i_tvalid = 1'b0;
      bus2.i_tdata  = '0;
      bus2.i_tlast  = 1'b0;
      bus2.o_tready = '1;
      clear_rx();

      #12;
      chk("rst_i_tready", 64'(bus.i_tready), 64'd1);
      chk("rst_o_tvalid", 64'(bus.o_tvalid), 64'd0);
      chk("rst_o_tlast", 64'(bus.o_tlast), 64'd0);
      chk("rst_o_tdata", 64'(bus.o_tdata), 64'd0);
      chk("rst_dropped", 64'(dropped_pkts), 64'd0);
      #11;
      reset = 1'b0;

      // 1: 8-beat packet, all ports ready, full throughput.
      en_mask = 3'b111;
      for (int i = 0; i < 8; i++) push_beat(WIDTH'(i), i == 7);
      for (int i = 0; i < 9; i++) begin
         tick();
         #1;
         if (i < 8) chk("t1_i_tready", 64'(bus.i_tready), 64'd1);
      end
      @(negedge clk);
      #1;
      for (int k = 0; k < SIZE; k++) chk("t1_rx_cnt", 64'(rx_cnt[k]), 64'd8);

      // 2: port 1 stalls for four cycles on beat 0.
      clear_rx();
      push_beat(32'd100, 1'b0);
      push_beat(32'd101, 1'b1);
      for (int c = 0; c < 6; c++) begin
         tick();
         bus.o_tready = (c == 5) ? 3'b111 : 3'b101;
         #1;
         chk("t2_i_tready", 64'(bus.i_tready), 64'((c == 0 || c == 5) ? 1 : 0));
         if (c == 2) chk("t2_o_tvalid", 64'(bus.o_tvalid), 64'b010);
      end
      wait_drain(50);
      for (int k = 0; k < SIZE; k++) chk("t2_rx_cnt", 64'(rx_cnt[k]), 64'd2);

      // 3: mask change mid-packet only takes effect on the next packet.
      clear_rx();
      en_mask = 3'b010;
      for (int i = 0; i < 4; i++) push_beat(WIDTH'(200 + i), i == 3);
      push_beat(32'd300, 1'b0);
      push_beat(32'd301, 1'b1);
      repeat (3) tick();
      en_mask = 3'b111;
      wait_drain(50);
      chk("t3_rx_p0", 64'(rx_cnt[0]), 64'd2);
      chk("t3_rx_p1", 64'(rx_cnt[1]), 64'd6);
      chk("t3_rx_p2", 64'(rx_cnt[2]), 64'd2);

      // 4: all-zero mask drops three packets.
      clear_rx();
      acc_cnt = 0;
      en_mask = 3'b000;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 4; i++) push_beat(WIDTH'(400 + 4 * p + i), i == 3);
      wait_drain(100);
      chk("t4_accepted", 64'(acc_cnt), 64'd12);
      for (int k = 0; k < SIZE; k++) chk("t4_rx_none", 64'(rx_cnt[k]), 64'd0);
      chk("t4_dropped", 64'(dropped_pkts), 64'd3);

      // Saturation on the 2-bit counter instance.
      @(posedge clk);
      #1;
      bus2.i_tvalid = 1'b1;
      bus2.i_tlast  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus2.i_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sat_two", 64'(drop2), 64'd2);
      bus2.i_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus2.i_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", 64'(drop2), 64'd3);

      // 5: random traffic, random ready, random masks.
      rnd_mode = 1'b1;
      for (int i = 0; i < 10000; i++)
         push_beat(WIDTH'($urandom), (i == 9999) || ($urandom_range(3) == 0));
      wait_drain(60000);
      rnd_mode = 1'b0;
      bus.o_tready = 3'b111;
      repeat (2) tick();
      chk("t5_dropped", 64'(dropped_pkts), 64'(exp_drop));

      // 6: async reset and sync clear with a mid-packet beat held.
      bus.o_tready = 3'b000;
      en_mask = 3'b111;
      push_beat(32'd500, 1'b0);
      tick();
      tick();
      #1;
      chk("t6_held_vld", 64'(bus.o_tvalid), 64'b111);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_rst_vld", 64'(bus.o_tvalid), 64'd0);
      chk("t6_rst_data", 64'(bus.o_tdata), 64'd0);
      chk("t6_rst_drop", 64'(dropped_pkts), 64'd0);
      chk("t6_rst_rdy", 64'(bus.i_tready), 64'd1);
      #3;
      reset = 1'b0;
      push_beat(32'd501, 1'b0);
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      chk("t6_clr_vld", 64'(bus.o_tvalid), 64'd0);
      chk("t6_clr_rdy", 64'(bus.i_tready), 64'd1);
      clear_rx();
      en_mask = 3'b001;
      bus.o_tready = 3'b111;
      push_beat(32'd502, 1'b1);
      wait_drain(20);
      chk("t6_rx_p0", 64'(rx_cnt[0]), 64'd1);
      chk("t6_rx_p1", 64'(rx_cnt[1]), 64'd0);
      chk("t6_rx_p2", 64'(rx_cnt[2]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
